// File: rtl/uart_fb_loader.sv
// uart_fb_loader: framed UART byte stream into the back bank of a dual-bank
// frame RAM, bank swap on frame boundary, and BPP-bit pixel unpack of the
// front bank for the VGA path.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for the 0xA5 sync byte
// S_HDR  | sync seen, waiting for 0x5A (repeated 0xA5 keeps us here)
// S_LOAD | writing payload bytes into the back bank
// S_DONE | frame loaded, waiting for new_frame to swap; bytes are dropped
module uart_fb_loader #(
    parameter int BPP         = 1,
    parameter int FRAME_BYTES = 38400,
    parameter int ADDR_W      = 16,
    parameter int RGB_W       = 16,
    parameter int TIMEOUT     = 25175
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_dv,
    input  logic [7:0]        rx_data,
    input  logic              new_frame,
    input  logic              pix_re,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic [ADDR_W:0]   ram_raddr,
    input  logic [7:0]        ram_rdata,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_ready,
    output logic              load_busy,
    output logic              err_timeout,
    output logic              err_drop
);

    localparam int SLOTS  = 8 / BPP;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int GAP_W  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_W-1:0] END_PTR   = ADDR_W'(FRAME_BYTES);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    // Reloaded on every byte so that the terminal count (1) is reached
    // exactly TIMEOUT-1 cycles later and the registered pulse lands on
    // cycle TIMEOUT after the byte.
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_TC    = GAP_W'(1);

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic                disp_bank;
    logic                pending;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [GAP_W-1:0]    gap_cnt;

    logic [ADDR_W-1:0]   rd_ptr;
    logic [SLOT_W-1:0]   slot;
    logic                req_d1;
    logic [SLOT_W-1:0]   slot_d1;
    logic [7:0]          shifted;
    logic [BPP-1:0]      pix_field;

    // Replicate a BPP-bit field MSB-first across the full RGB width.
    function automatic logic [RGB_W-1:0] expand(input logic [BPP-1:0] f);
        logic [RGB_W-1:0] r;
        r = '0;
        for (int i = 0; i < RGB_W; i++) begin
            r[RGB_W-1-i] = f[BPP-1-(i % BPP)];
        end
        return r;
    endfunction

    // Parser FSM, gap timer, bank swap and registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            disp_bank   <= 1'b0;
            pending     <= 1'b0;
            wr_ptr      <= '0;
            gap_cnt     <= '0;
            ram_we      <= 1'b0;
            ram_waddr   <= '0;
            ram_wdata   <= '0;
            frame_ready <= 1'b0;
            load_busy   <= 1'b0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            ram_we      <= 1'b0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;

            if (rx_dv) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_HDR || state == S_LOAD) && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_TC;
            end

            case (state)
                S_IDLE: begin
                    if (rx_dv && rx_data == SYNC0) begin
                        state     <= S_HDR;
                        load_busy <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (rx_dv) begin
                        if (rx_data == SYNC1) begin
                            state  <= S_LOAD;
                            wr_ptr <= '0;
                        end else if (rx_data != SYNC0) begin
                            state     <= S_IDLE;
                            load_busy <= 1'b0;
                        end
                    end else if (gap_cnt == GAP_TC) begin
                        state       <= S_IDLE;
                        load_busy   <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rx_dv) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= {~disp_bank, wr_ptr};
                        ram_wdata <= rx_data;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == LAST_BYTE) begin
                            pending   <= 1'b1;
                            state     <= S_DONE;
                            load_busy <= 1'b0;
                        end
                    end else if (gap_cnt == GAP_TC) begin
                        // partial back bank is simply abandoned
                        state       <= S_IDLE;
                        load_busy   <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (rx_dv) begin
                        err_drop <= 1'b1;
                    end
                    if (new_frame) begin
                        disp_bank   <= ~disp_bank;
                        pending     <= 1'b0;
                        frame_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_raddr = {disp_bank, rd_ptr};

    // Read pointer and slot; new_frame rewinds and beats any pixel request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            slot   <= '0;
        end else if (new_frame) begin
            rd_ptr <= '0;
            slot   <= '0;
        end else if (pix_re && rd_ptr != END_PTR) begin
            if (slot == LAST_SLOT) begin
                slot   <= '0;
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end else begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

    assign shifted   = ram_rdata << (slot_d1 * BPP);
    assign pix_field = shifted[7 -: BPP];

    // Two-stage pixel pipeline aligned with the 1-cycle RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d1  <= 1'b0;
            slot_d1 <= '0;
            rgb     <= '0;
        end else begin
            req_d1  <= pix_re && !new_frame && (rd_ptr != END_PTR);
            slot_d1 <= slot;
            rgb     <= (req_d1 && frame_ready) ? expand(pix_field) : '0;
        end
    end

endmodule

// File: tb/tb_uart_fb_loader.sv
// Directed bench for uart_fb_loader with BPP=2, 16-byte frames, TIMEOUT=100.
module tb_uart_fb_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic        new_frame;
    logic        pix_re;
    logic        ram_we;
    logic [16:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic [16:0] ram_raddr;
    logic [7:0]  ram_rdata;
    logic [15:0] rgb;
    logic        frame_ready;
    logic        load_busy;
    logic        err_timeout;
    logic        err_drop;
    logic [62:0] all_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];

    uart_fb_loader #(
        .BPP(2), .FRAME_BYTES(16), .ADDR_W(16), .RGB_W(16), .TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_data(rx_data),
        .new_frame(new_frame), .pix_re(pix_re), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .rgb(rgb), .frame_ready(frame_ready),
        .load_busy(load_busy), .err_timeout(err_timeout), .err_drop(err_drop)
    );

    assign all_out = {ram_we, ram_waddr, ram_wdata, ram_raddr, rgb,
                      frame_ready, load_busy, err_timeout, err_drop};

    always #5 clk = ~clk;

    // Small synchronous RAM model: 16 bytes per bank, two banks.
    always @(posedge clk) begin
        if (ram_we) mem[{ram_waddr[16], ram_waddr[3:0]}] <= ram_wdata;
        ram_rdata <= mem[{ram_raddr[16], ram_raddr[3:0]}];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        tick();
        send_byte(8'hA5);
        pix_re = 1'b1;
        send_byte(8'h5A);
        pix_re = 1'b0;
        send_byte(8'h00);
        pix_re = 1'b1;
        send_byte(8'h01);
        checks++;
        if (load_busy !== 1'b1) begin
            errors++;
            $display("FAIL midload_busy: got %b expected 1", load_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midload_reset_async: got %h expected 0", all_out);
        end
        tick();
        pix_re = 1'b0;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midload_reset_hold: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        tick();
        send_byte(8'h5A);
        send_byte(8'h00);
        checks++;
        if (ram_we !== 1'b0 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_load_after_5a: got we=%b busy=%b expected 0 0", ram_we, load_busy);
        end
    endtask

    task automatic test_full_load();
        logic [7:0] d;
        send_byte(8'hA5);
        send_byte(8'h5A);
        checks++;
        if (load_busy !== 1'b1) begin
            errors++;
            $display("FAIL hdr_busy: got %b expected 1", load_busy);
        end
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? 8'hE4 : 8'(i);
            send_byte(d);
            checks++;
            if (ram_we !== 1'b1 || ram_waddr !== 17'h10000 + 17'(i) || ram_wdata !== d) begin
                errors++;
                $display("FAIL load_write[%0d]: got we=%b addr=%h data=%h expected 1 %h %h",
                         i, ram_we, ram_waddr, ram_wdata, 17'h10000 + 17'(i), d);
            end
        end
        checks++;
        if (load_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: got %b expected 0", load_busy);
        end
        tick();
        checks++;
        if (ram_we !== 1'b0 || frame_ready !== 1'b0 || ram_raddr !== 17'h00000) begin
            errors++;
            $display("FAIL pre_swap: got we=%b ready=%b raddr=%h expected 0 0 00000",
                     ram_we, frame_ready, ram_raddr);
        end
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        checks++;
        if (frame_ready !== 1'b1 || ram_raddr !== 17'h10000) begin
            errors++;
            $display("FAIL swap: got ready=%b raddr=%h expected 1 10000", frame_ready, ram_raddr);
        end
    endtask

    task automatic test_unpack();
        logic [15:0] obs [0:5];
        logic [15:0] exp_rgb [0:4];
        exp_rgb[0] = 16'h0000;
        exp_rgb[1] = 16'hFFFF;
        exp_rgb[2] = 16'hAAAA;
        exp_rgb[3] = 16'h5555;
        exp_rgb[4] = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            pix_re = (k < 4);
            tick();
            obs[k] = rgb;
        end
        pix_re = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs[k] !== exp_rgb[k]) begin
                errors++;
                $display("FAIL unpack_rgb[%0d]: got %h expected %h", k, obs[k], exp_rgb[k]);
            end
        end
        checks++;
        if (ram_raddr !== 17'h10001) begin
            errors++;
            $display("FAIL unpack_rdptr: got %h expected 10001", ram_raddr);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 63; k++) begin
            pix_re = 1'b1;
            tick();
            if (k + 1 == 21) begin
                checks++;
                if (rgb !== 16'h5555) begin
                    errors++;
                    $display("FAIL sat_mid_pixel: got %h expected 5555", rgb);
                end
            end
            if (k + 1 == 61) begin
                checks++;
                if (rgb !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL sat_last_pixel: got %h expected ffff", rgb);
                end
            end
            if (k + 1 == 62 || k + 1 == 63) begin
                checks++;
                if (rgb !== 16'h0000) begin
                    errors++;
                    $display("FAIL sat_past_end: got %h expected 0000", rgb);
                end
            end
        end
        pix_re = 1'b0;
        checks++;
        if (ram_raddr !== 17'h10010) begin
            errors++;
            $display("FAIL sat_rdptr: got %h expected 10010", ram_raddr);
        end
    endtask

    task automatic test_same_cycle();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        pix_re    = 1'b1;
        tick();
        new_frame = 1'b1;
        pix_re    = 1'b1;
        tick();
        new_frame = 1'b0;
        pix_re    = 1'b0;
        checks++;
        if (ram_raddr !== 17'h10000 || rgb !== 16'hFFFF) begin
            errors++;
            $display("FAIL same_cycle_ptr: got raddr=%h rgb=%h expected 10000 ffff", ram_raddr, rgb);
        end
        tick();
        checks++;
        if (rgb !== 16'h0000) begin
            errors++;
            $display("FAIL same_cycle_rgb: got %h expected 0000", rgb);
        end
        pix_re = 1'b1;
        tick();
        pix_re = 1'b0;
        tick();
        checks++;
        if (rgb !== 16'hFFFF) begin
            errors++;
            $display("FAIL same_cycle_slot_rewind: got %h expected ffff", rgb);
        end
    endtask

    task automatic test_timeout();
        int k;
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h10);
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== 17'h00000 || ram_wdata !== 8'h10) begin
            errors++;
            $display("FAIL to_write_bank: got we=%b addr=%h data=%h expected 1 00000 10",
                     ram_we, ram_waddr, ram_wdata);
        end
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h13);
        send_byte(8'h14);
        k = 1;
        while (err_timeout !== 1'b1 && k < 150) begin
            tick();
            k++;
        end
        checks++;
        if (k != 100) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected 100", k);
        end
        checks++;
        if (load_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b expected 0", load_busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got %b expected 0", err_timeout);
        end
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        checks++;
        if (ram_raddr !== 17'h10000 || frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_no_swap: got raddr=%h ready=%b expected 10000 1",
                     ram_raddr, frame_ready);
        end
    endtask

    task automatic test_drop_resync();
        int drops;
        send_byte(8'hA5);
        send_byte(8'h5A);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h80 + 8'(i));
        end
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== 17'h0000F || ram_wdata !== 8'h8F) begin
            errors++;
            $display("FAIL load2_last: got we=%b addr=%h data=%h expected 1 0000f 8f",
                     ram_we, ram_waddr, ram_wdata);
        end
        drops = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hC0 + 8'(i));
            if (err_drop === 1'b1 && ram_we === 1'b0) drops++;
        end
        checks++;
        if (drops != 3) begin
            errors++;
            $display("FAIL drop_count: got %0d expected 3", drops);
        end
        rx_data   = 8'h77;
        rx_dv     = 1'b1;
        new_frame = 1'b1;
        tick();
        rx_dv     = 1'b0;
        new_frame = 1'b0;
        checks++;
        if (err_drop !== 1'b1 || ram_we !== 1'b0 || ram_raddr !== 17'h00000) begin
            errors++;
            $display("FAIL swap_with_byte: got drop=%b we=%b raddr=%h expected 1 0 00000",
                     err_drop, ram_we, ram_raddr);
        end
        pix_re = 1'b1;
        tick();
        pix_re = 1'b0;
        checks++;
        if (err_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse: got %b expected 0", err_drop);
        end
        tick();
        checks++;
        if (rgb !== 16'hAAAA) begin
            errors++;
            $display("FAIL bank0_pixel: got %h expected aaaa", rgb);
        end
        send_byte(8'hA5);
        send_byte(8'hA5);
        checks++;
        if (load_busy !== 1'b1) begin
            errors++;
            $display("FAIL resync_hdr: got %b expected 1", load_busy);
        end
        send_byte(8'h5A);
        send_byte(8'h33);
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== 17'h10000 || ram_wdata !== 8'h33) begin
            errors++;
            $display("FAIL resync_load: got we=%b addr=%h data=%h expected 1 10000 33",
                     ram_we, ram_waddr, ram_wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        rst_n     = 1'b0;
        rx_dv     = 1'b0;
        rx_data   = 8'h00;
        new_frame = 1'b0;
        pix_re    = 1'b0;
        test_reset();
        test_full_load();
        test_unpack();
        test_saturate();
        test_same_cycle();
        test_timeout();
        test_drop_resync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
